// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared op encodings, FSM states and default width for the multi-cycle unit
package mcycle_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
endpackage

// File: rtl/mcycle_divstep.sv
// mcycle_divstep: one combinational restoring shift-subtract step of an unsigned divide
module mcycle_divstep
  import mcycle_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext,
  output logic [WIDTH-1:0] quoNext
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign ge      = shifted >= {1'b0, divisor};
  assign remNext = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quoNext = {quo[WIDTH-2:0], ge};
endmodule

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative unsigned multiply/divide, one step per cycle; divide built only with MCYCLE_DIV_EN
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t         state, stateNext;
  logic           opReg;
  logic [WIDTH-1:0] opnd2, hi, lo;
  logic [CW-1:0]  cnt;
  logic [WIDTH:0] mulSum;
  logic [WIDTH-1:0] mulHi, mulLo, divHi, divLo, stepHi, stepLo;
  // hi/lo hold accumulator:multiplier for multiply, remainder:quotient for divide
  assign mulSum = {1'b0, hi} + (lo[0] ? {1'b0, opnd2} : '0);
  assign mulHi  = mulSum[WIDTH:1];
  assign mulLo  = {mulSum[0], lo[WIDTH-1:1]};
`ifdef MCYCLE_DIV_EN
  mcycle_divstep #(.WIDTH(WIDTH)) uDivStep (
    .rem    (hi),
    .quo    (lo),
    .divisor(opnd2),
    .remNext(divHi),
    .quoNext(divLo)
  );
`else
  assign divHi = '0;
  assign divLo = '0;
`endif
  assign stepHi = (opReg == OP_DIV) ? divHi : mulHi;
  assign stepLo = (opReg == OP_DIV) ? divLo : mulLo;
  always_comb begin
    Busy      = ((state == IDLE) && Start) || (state == COMPUTE);
    stateNext = (state == IDLE)    ? (Start ? COMPUTE : IDLE) :
                (state == COMPUTE) ? ((cnt == LAST) ? DONE : COMPUTE) : IDLE;
  end
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= IDLE;
      opReg   <= 1'b0;
      opnd2   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      Result1 <= '0;
      Result2 <= '0;
    end else begin
      state <= stateNext;
      if ((state == IDLE) && Start) begin
        opReg <= MCycleOp;
        opnd2 <= Operand2;
        hi    <= '0;
        lo    <= Operand1;
        cnt   <= '0;
      end else if (state == COMPUTE) begin
        hi  <= stepHi;
        lo  <= stepLo;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          Result1 <= stepLo;
          Result2 <= stepHi;
        end
      end
    end
  end
endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: randomized self-checking bench for mcycle_unit against an arithmetic reference model
module tb_mcycle_unit;
  localparam int W = 32;
  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  logic Start = 1'b0;
  logic MCycleOp = 1'b0;
  logic [W-1:0] Operand1 = '0;
  logic [W-1:0] Operand2 = '0;
  logic [W-1:0] Result1, Result2;
  logic Busy;
  int errCnt = 0;
  int chkCnt = 0;
  logic [W-1:0] prevR1 = '0;
  logic [W-1:0] prevR2 = '0;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RESETn(RESETn), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] r;
    if (op == 1'b0) r = 64'(a) * 64'(b);
`ifdef MCYCLE_DIV_EN
    else if (b == 0) r = {a, {W{1'b1}}};
    else r = {a % b, a / b};
`else
    else r = '0;
`endif
    return r;
  endfunction

  // called just after a rising edge with the unit in IDLE; returns just after an edge in IDLE
  task automatic doOp(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit noisy, input bit holdStart);
    logic [63:0] exp;
    int busyCnt;
    exp = model(op, a, b);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    #1;
    check("busy_same_cycle", 64'(Busy), 64'(1));
    busyCnt = 0;
    for (int i = 0; i < W + 4 && Busy; i++) begin
      busyCnt++;
      @(posedge CLK); #1;
      if (busyCnt == W) check("result_held_early", {Result2, Result1}, {prevR2, prevR1});
      if (noisy) begin
        Operand1 = $urandom; Operand2 = $urandom; MCycleOp = 1'($urandom); Start = 1'($urandom);
      end else if (!holdStart) Start = 1'b0;
    end
    Start = holdStart;
    #1;
    check("busy_cycles", 64'(busyCnt), 64'(W + 1));
    check("busy_done", 64'(Busy), 64'(0));
    check($sformatf("result_op%0d", op), {Result2, Result1}, exp);
    prevR1 = exp[W-1:0];
    prevR2 = exp[63:W];
    @(posedge CLK); #1;
    check("busy_idle", 64'(Busy), 64'(holdStart));
    check("result_idle", {Result2, Result1}, exp);
  endtask

  initial begin
    #2;
    check("rst_busy", 64'(Busy), 64'(0));
    check("rst_results", {Result2, Result1}, 64'(0));
    #20;
    @(posedge CLK); #1;
    RESETn = 1'b1;
    doOp(1'b0, 32'h7, 32'h6, 1'b0, 1'b0);
    doOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    doOp(1'b1, 32'd100, 32'd7, 1'b0, 1'b0);
    doOp(1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
    doOp(1'b0, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
    doOp(1'b1, 32'd3, 32'd10, 1'b0, 1'b0);
    doOp(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
    doOp(1'b0, 32'h0001_0003, 32'h0002_0005, 1'b0, 1'b0);
    doOp(1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b0);
    doOp(1'b1, 32'hFFFF_FFF0, 32'h0000_0013, 1'b1, 1'b0);
    Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'hFFFF; Operand2 = 32'hFFFF;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RESETn = 1'b0;
    #1;
    check("abort_busy", 64'(Busy), 64'(0));
    check("abort_results", {Result2, Result1}, 64'(0));
    prevR1 = '0; prevR2 = '0;
    @(posedge CLK); #1;
    RESETn = 1'b1;
    check("abort_still_zero", {Result2, Result1}, 64'(0));
    doOp(1'b0, 32'd12345, 32'd678, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++)
      doOp(1'($urandom), $urandom, (k % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom,
           1'($urandom), 1'b0);
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
